// File: rtl/div_dispatch_pkg.sv
// Types shared by the divide dispatch controller, its result FIFO and the divider.
package div_dispatch_pkg;

   localparam int ADDR_BITS = 4;

   typedef enum logic [2:0] {
      NONE_OP = 3'd0,
      DIV     = 3'd1,
      DIVU    = 3'd2,
      REM     = 3'd3,
      REMU    = 3'd4
   } fu_op_t;

   typedef struct packed {
      fu_op_t                op;
      logic [31:0]           op1;
      logic [31:0]           op2;
      logic [ADDR_BITS-1:0]  trans_id;
   } div_req_t;

   function automatic logic is_div_op(input fu_op_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

endpackage

// File: rtl/div_res_fifo.sv
// Small result FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module div_res_fifo #(
   parameter int  DEPTH = 2,
   parameter int  WIDTH = 36,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i & (cnt_q != '0);
   // a push into a full FIFO is dropped unless a pop frees the slot this cycle
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];
   assign cnt_o   = cnt_q;

   // pointer and occupancy bookkeeping; flush empties the FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // storage array, no reset needed since the pointers qualify every read
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/div_dispatch.sv
// Initiator-side controller for the divide unit: holds one request, reserves
// a result slot before forwarding it, and buffers results for writeback.
module div_dispatch
   import div_dispatch_pkg::*;
#(
   parameter int TRANS_W   = ADDR_BITS,
   parameter int RES_DEPTH = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_ex_i,
   input  logic               issue_vld_i,
   output logic               issue_rdy_o,
   input  fu_op_t             issue_op_i,
   input  logic [31:0]        issue_op1_i,
   input  logic [31:0]        issue_op2_i,
   input  logic [TRANS_W-1:0] issue_trans_id_i,
   output logic               div_vld_o,
   input  logic               div_rdy_i,
   output fu_op_t             div_op_o,
   output logic [31:0]        div_op1_o,
   output logic [31:0]        div_op2_o,
   output logic [TRANS_W-1:0] div_trans_id_o,
   input  logic               div_vld_i,
   input  logic [TRANS_W-1:0] div_trans_id_i,
   input  logic [31:0]        div_result_i,
   output logic               wb_vld_o,
   input  logic               wb_rdy_i,
   output logic [TRANS_W-1:0] wb_trans_id_o,
   output logic [31:0]        wb_result_o,
   output logic               proto_err_o
);

   localparam int CNT_W  = $clog2(RES_DEPTH + 1);
   localparam int USED_W = CNT_W + 1;
   localparam int RES_W  = TRANS_W + 32;

   logic               req_vld_q;
   fu_op_t             req_op_q;
   logic [31:0]        req_op1_q;
   logic [31:0]        req_op2_q;
   logic [TRANS_W-1:0] req_id_q;
   logic               inflight_q;
   logic               proto_err_q;

   logic [CNT_W-1:0]   fifo_cnt;
   logic               fifo_full;
   logic [RES_W-1:0]   fifo_data;
   logic [USED_W-1:0]  used;
   logic               credit_ok;
   logic               div_hsk;
   logic               issue_hsk;
   logic               wb_hsk;
   logic               fifo_push;
   logic               proto_set;

   // a request may only go out while a result slot is guaranteed for it
   assign used      = USED_W'(fifo_cnt) + USED_W'(inflight_q);
   assign credit_ok = used < USED_W'(RES_DEPTH);

   assign div_vld_o   = req_vld_q & credit_ok & ~flush_ex_i;
   assign div_hsk     = div_vld_o & div_rdy_i;
   assign issue_rdy_o = (~req_vld_q | div_hsk) & ~flush_ex_i;
   assign issue_hsk   = issue_vld_i & issue_rdy_o;

   assign div_op_o       = req_op_q;
   assign div_op1_o      = req_op1_q;
   assign div_op2_o      = req_op2_q;
   assign div_trans_id_o = req_id_q;

   assign fifo_push = div_vld_i & ~flush_ex_i;
   assign wb_vld_o  = (fifo_cnt != '0);
   assign wb_hsk    = wb_vld_o & wb_rdy_i;
   assign {wb_trans_id_o, wb_result_o} = wb_vld_o ? fifo_data : '0;

   // a result nobody asked for, or one with no room, is a divider protocol violation
   assign proto_set   = ~flush_ex_i &
                        ((div_vld_i & ~inflight_q & ~div_hsk) | (fifo_push & fifo_full));
   assign proto_err_o = proto_err_q;

   // single-entry request register; a reload in the handshake cycle keeps it full
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_vld_q <= 1'b0;
         req_op_q  <= NONE_OP;
         req_op1_q <= '0;
         req_op2_q <= '0;
         req_id_q  <= '0;
      end else if (flush_ex_i) begin
         req_vld_q <= 1'b0;
      end else if (issue_hsk) begin
         req_vld_q <= 1'b1;
         req_op_q  <= issue_op_i;
         req_op1_q <= issue_op1_i;
         req_op2_q <= issue_op2_i;
         req_id_q  <= issue_trans_id_i;
      end else if (div_hsk) begin
         req_vld_q <= 1'b0;
      end
   end

   // one division outstanding at most; same-cycle fast results never set it
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_ex_i) begin
         inflight_q <= 1'b0;
      end else if (div_vld_i) begin
         inflight_q <= 1'b0;
      end else if (div_hsk) begin
         inflight_q <= 1'b1;
      end
   end

   // sticky protocol error flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         proto_err_q <= 1'b0;
      end else if (proto_set) begin
         proto_err_q <= 1'b1;
      end
   end

   div_res_fifo #(
      .DEPTH (RES_DEPTH),
      .WIDTH (RES_W)
   ) u_res_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_ex_i),
      .push_i  (fifo_push),
      .data_i  ({div_trans_id_i, div_result_i}),
      .pop_i   (wb_hsk),
      .data_o  (fifo_data),
      .cnt_o   (fifo_cnt),
      .full_o  (fifo_full)
   );

   op_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
      issue_vld_i |-> is_div_op(issue_op_i));

endmodule

// File: tb/tb_div_dispatch.sv
// Randomized bench for div_dispatch with a behavioural divider and scoreboard.
`timescale 1ns/1ps
module tb_div_dispatch;
   import div_dispatch_pkg::*;

   localparam int TRANS_W   = ADDR_BITS;
   localparam int RES_DEPTH = 2;
   localparam int N_CYC     = 4000;
   localparam int N_DIR     = 6;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               flush_ex_i;
   logic               issue_vld_i;
   logic               issue_rdy_o;
   fu_op_t             issue_op_i;
   logic [31:0]        issue_op1_i;
   logic [31:0]        issue_op2_i;
   logic [TRANS_W-1:0] issue_trans_id_i;
   logic               div_vld_o;
   logic               div_rdy_i;
   fu_op_t             div_op_o;
   logic [31:0]        div_op1_o;
   logic [31:0]        div_op2_o;
   logic [TRANS_W-1:0] div_trans_id_o;
   logic               div_vld_i;
   logic [TRANS_W-1:0] div_trans_id_i;
   logic [31:0]        div_result_i;
   logic               wb_vld_o;
   logic               wb_rdy_i;
   logic [TRANS_W-1:0] wb_trans_id_o;
   logic [31:0]        wb_result_o;
   logic               proto_err_o;

   div_dispatch #(.TRANS_W(TRANS_W), .RES_DEPTH(RES_DEPTH)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_ex_i       (flush_ex_i),
      .issue_vld_i      (issue_vld_i),
      .issue_rdy_o      (issue_rdy_o),
      .issue_op_i       (issue_op_i),
      .issue_op1_i      (issue_op1_i),
      .issue_op2_i      (issue_op2_i),
      .issue_trans_id_i (issue_trans_id_i),
      .div_vld_o        (div_vld_o),
      .div_rdy_i        (div_rdy_i),
      .div_op_o         (div_op_o),
      .div_op1_o        (div_op1_o),
      .div_op2_o        (div_op2_o),
      .div_trans_id_o   (div_trans_id_o),
      .div_vld_i        (div_vld_i),
      .div_trans_id_i   (div_trans_id_i),
      .div_result_i     (div_result_i),
      .wb_vld_o         (wb_vld_o),
      .wb_rdy_i         (wb_rdy_i),
      .wb_trans_id_o    (wb_trans_id_o),
      .wb_result_o      (wb_result_o),
      .proto_err_o      (proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // RISC-V M-extension divide semantics
   function automatic logic [31:0] ref_div(input fu_op_t op, input logic [31:0] a, input logic [31:0] b);
      int  sa;
      int  sb;
      logic ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REMU:    return (b == 0) ? a : a % b;
         DIV:     return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
         REM:     return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 200));
         default: return $urandom;
      endcase
   endfunction

   // directed vectors with hand-derived results
   fu_op_t             d_op  [N_DIR] = '{DIVU, REMU, DIV, REM, DIV, DIVU};
   logic [31:0]        d_a   [N_DIR] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
   logic [31:0]        d_b   [N_DIR] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
   logic [31:0]        d_exp [N_DIR] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
   logic [TRANS_W-1:0] d_id  [N_DIR] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

   typedef struct {
      logic [TRANS_W-1:0] id;
      logic [31:0]        res;
   } exp_t;

   exp_t               exp_q[$];
   int                 m_avail;
   bit                 m_held;
   fu_op_t             m_op;
   logic [31:0]        m_a, m_b;
   logic [TRANS_W-1:0] m_id;

   bit                 dv_busy;
   int                 dv_cnt;
   logic [TRANS_W-1:0] dv_id;
   logic [31:0]        dv_res;

   bit                 iss_pend;
   logic [31:0]        p_exp;
   int                 dir_idx;

   task automatic idle_inputs();
      flush_ex_i       = 1'b0;
      issue_vld_i      = 1'b0;
      issue_op_i       = DIV;
      issue_op1_i      = '0;
      issue_op2_i      = '0;
      issue_trans_id_i = '0;
      div_rdy_i        = 1'b0;
      div_vld_i        = 1'b0;
      div_trans_id_i   = '0;
      div_result_i     = '0;
      wb_rdy_i         = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_avail  = 0;
      m_held   = 1'b0;
      dv_busy  = 1'b0;
      dv_cnt   = 0;
      iss_pend = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_issue_rdy"}, issue_rdy_o, 1'b1);
      check_val({tag, "_div_vld"},   div_vld_o, 1'b0);
      check_val({tag, "_wb_vld"},    wb_vld_o, 1'b0);
      check_val({tag, "_div_op"},    div_op_o, NONE_OP);
      check_val({tag, "_div_op1"},   div_op1_o, 32'h0);
      check_val({tag, "_div_op2"},   div_op2_o, 32'h0);
      check_val({tag, "_div_id"},    div_trans_id_o, 0);
      check_val({tag, "_wb_id"},     wb_trans_id_o, 0);
      check_val({tag, "_wb_res"},    wb_result_o, 32'h0);
      check_val({tag, "_proto"},     proto_err_o, 1'b0);
   endtask

   initial begin
      bit flush, fired, fast, exp_dvld, exp_irdy, exp_wvld, model_hsk;
      int ph, lat;

      idle_inputs();
      clear_model();
      dir_idx = 0;
      rst_i   = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_reset_outputs("reset");

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk_i);
         #1;
         flush      = (cyc > 600) && ($urandom_range(0, 99) < 2);
         flush_ex_i = flush;
         ph         = (cyc / 80) % 3;
         wb_rdy_i   = !flush && (ph == 0 ? ($urandom_range(0, 99) < 90) :
                                 ph == 1 ? ($urandom_range(0, 99) < 50) :
                                           ($urandom_range(0, 99) < 5));
         fired          = 1'b0;
         div_vld_i      = 1'b0;
         div_trans_id_i = '0;
         div_result_i   = '0;
         if (dv_busy && !flush && dv_cnt == 0) begin
            div_vld_i      = 1'b1;
            div_trans_id_i = dv_id;
            div_result_i   = dv_res;
            fired          = 1'b1;
         end
         div_rdy_i = !dv_busy && ($urandom_range(0, 3) != 0);

         if (!iss_pend) begin
            issue_vld_i = 1'b0;
            iss_pend    = 1'b1;
            if (dir_idx < N_DIR) begin
               issue_op_i       = d_op[dir_idx];
               issue_op1_i      = d_a[dir_idx];
               issue_op2_i      = d_b[dir_idx];
               issue_trans_id_i = d_id[dir_idx];
               p_exp            = d_exp[dir_idx];
               dir_idx++;
            end else begin
               case ($urandom_range(0, 3))
                  0:       issue_op_i = DIV;
                  1:       issue_op_i = DIVU;
                  2:       issue_op_i = REM;
                  default: issue_op_i = REMU;
               endcase
               issue_op1_i      = rnd_opnd();
               issue_op2_i      = rnd_opnd();
               issue_trans_id_i = TRANS_W'($urandom);
               p_exp            = ref_div(issue_op_i, issue_op1_i, issue_op2_i);
            end
         end
         if (!issue_vld_i) issue_vld_i = ($urandom_range(0, 2) != 0);

         // divider accepts what the DUT actually offers; some ops finish in the same cycle
         #1;
         fast = 1'b0;
         if (div_vld_o && div_rdy_i) begin
            fast = (div_op2_o == 0) || (div_op2_o == 1) || (div_op2_o == 32'hFFFF_FFFF) ||
                   ($urandom_range(0, 3) == 0);
            if (fast) begin
               div_vld_i      = 1'b1;
               div_trans_id_i = div_trans_id_o;
               div_result_i   = ref_div(div_op_o, div_op1_o, div_op2_o);
            end
         end

         @(negedge clk_i);
         exp_dvld  = m_held && (m_avail + int'(dv_busy) < RES_DEPTH) && !flush;
         model_hsk = exp_dvld && div_rdy_i;
         exp_irdy  = !flush && (!m_held || model_hsk);
         exp_wvld  = (m_avail != 0);

         check_val("div_vld", div_vld_o, exp_dvld);
         if (exp_dvld) begin
            check_val("div_op",  div_op_o, m_op);
            check_val("div_op1", div_op1_o, m_a);
            check_val("div_op2", div_op2_o, m_b);
            check_val("div_id",  div_trans_id_o, m_id);
         end
         check_val("issue_rdy", issue_rdy_o, exp_irdy);
         check_val("wb_vld", wb_vld_o, exp_wvld);
         if (exp_wvld && exp_q.size() > 0) begin
            check_val("wb_id",  wb_trans_id_o, exp_q[0].id);
            check_val("wb_res", wb_result_o, exp_q[0].res);
         end
         check_val("proto_err", proto_err_o, 1'b0);

         if (flush) begin
            clear_model();
         end else begin
            if (exp_wvld && wb_rdy_i && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               m_avail--;
            end
            if (div_vld_i) m_avail++;
            if (fired) dv_busy = 1'b0;
            else if (dv_busy) dv_cnt--;
            if (div_vld_o && div_rdy_i && !fast) begin
               lat     = ($urandom_range(0, 9) == 0) ? 32 : int'($urandom_range(1, 6));
               dv_busy = 1'b1;
               dv_cnt  = lat - 1;
               dv_id   = div_trans_id_o;
               dv_res  = ref_div(div_op_o, div_op1_o, div_op2_o);
            end
            if (model_hsk) m_held = 1'b0;
            if (issue_vld_i && exp_irdy) begin
               m_held = 1'b1;
               m_op   = issue_op_i;
               m_a    = issue_op1_i;
               m_b    = issue_op2_i;
               m_id   = issue_trans_id_i;
               exp_q.push_back('{id: issue_trans_id_i, res: p_exp});
               iss_pend = 1'b0;
            end
         end
      end

      // reset in the middle of traffic behaves like a flush
      @(posedge clk_i);
      #1;
      idle_inputs();
      rst_i = 1'b1;
      clear_model();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_reset_outputs("midrst");

      // stray result with nothing inflight
      @(posedge clk_i);
      #1;
      div_vld_i      = 1'b1;
      div_trans_id_i = TRANS_W'(5);
      div_result_i   = 32'h1234;
      @(negedge clk_i);
      check_val("proto_pre", proto_err_o, 1'b0);
      @(posedge clk_i);
      #1 div_vld_i = 1'b0;
      @(negedge clk_i);
      check_val("proto_set", proto_err_o, 1'b1);
      repeat (5) @(posedge clk_i);
      #1 flush_ex_i = 1'b1;
      @(posedge clk_i);
      #1 flush_ex_i = 1'b0;
      @(negedge clk_i);
      check_val("proto_sticky", proto_err_o, 1'b1);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_val("proto_clr", proto_err_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/div_dispatch.md
Name: div_dispatch

Overview:
Initiator-side controller for the divide functional unit in the execute stage. It accepts DIV/DIVU/REM/REMU requests from issue with a valid/ready handshake and holds each one in a request register until the divider accepts it. The divider's result port has no backpressure, so the block reserves a result slot before forwarding any request. Results are buffered and presented to writeback with a valid/ready handshake; flush_ex_i discards everything held.

Parameters:
TRANS_W, ADDR_BITS, width of transaction id
RES_DEPTH, 2, result FIFO entries (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
flush_ex_i  in  1  execute-stage flush
issue_vld_i  in  1  issue request valid
issue_rdy_o  out  1  issue request ready
issue_op_i  in  fu_op_t  operation
issue_op1_i  in  32  dividend
issue_op2_i  in  32  divisor
issue_trans_id_i  in  TRANS_W  transaction id
div_vld_o  out  1  request valid to divider
div_rdy_i  in  1  divider ready
div_op_o  out  fu_op_t  operation to divider
div_op1_o  out  32  dividend to divider
div_op2_o  out  32  divisor to divider
div_trans_id_o  out  TRANS_W  id to divider
div_vld_i  in  1  divider result valid (no backpressure)
div_trans_id_i  in  TRANS_W  result id
div_result_i  in  32  quotient/remainder
wb_vld_o  out  1  writeback valid
wb_rdy_i  in  1  writeback ready
wb_trans_id_o  out  TRANS_W  writeback id
wb_result_o  out  32  writeback data
proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i=1 at posedge): request register empty, inflight_q=0, FIFO empty, proto_err_o=0. Outputs after reset: issue_rdy_o=1, div_vld_o=0, wb_vld_o=0, div_op_o=NONE_OP, data/id outputs 0.
- Request register (1 entry): req_vld_q plus captured op, operands and id. Loads on issue_hsk = issue_vld_i & issue_rdy_o.
- issue_rdy_o = ~req_vld_q | div_hsk. Back-to-back issue is allowed when the held request leaves in the same cycle.
- Credits: free = RES_DEPTH - fifo_cnt - inflight_q.
- div_vld_o = req_vld_q & (free != 0) & ~flush_ex_i. The div_*_o outputs come directly from the request register.
- div_hsk = div_vld_o & div_rdy_i. On div_hsk: req_vld_q clears unless it reloads the same cycle.
- Inflight tracking: inflight_q sets on div_hsk unless div_vld_i is also high that cycle; it clears on div_vld_i. This covers the divider's same-cycle fast paths (|a|<|b|, divide by zero, divide by ±1, overflow).
- Result FIFO: push on div_vld_i & ~flush_ex_i with {div_trans_id_i, div_result_i}. Pop on wb_vld_o & wb_rdy_i. Push and pop in the same cycle keep the count unchanged; pointers wrap modulo RES_DEPTH.
- wb_vld_o = fifo_cnt != 0. Latency from div_vld_i to wb_vld_o is 1 cycle; there is no bypass. The wb_* outputs hold stable while wb_vld_o=1 and wb_rdy_i=0.
- Credits guarantee that a push never hits a full FIFO.
- Protocol error (sticky until reset) is set by either:
  - div_vld_i while inflight_q=0 and no div_hsk this cycle, or
  - a push while the FIFO is full.
- Flush (takes priority over all other updates): clear request register, inflight_q and FIFO. issue_hsk in the flush cycle is ignored and issue_rdy_o is forced to 0. wb_vld_o drops the next cycle.
- Reset mid-operation behaves the same as flush; a stray late div_vld_i after reset sets proto_err_o.
- issue_op_i outside DIV/DIVU/REM/REMU is illegal; enforced by assertion only.

Decomposition:
- Shared package: fu_op_t, ADDR_BITS, NONE_OP, and a div_req_t struct {op, op1, op2, trans_id} reused by the divider.
- One sub-module: div_res_fifo, a parameterised FIFO with cnt output and push/pop/flush inputs.

Test Plan:
- DIVU 100/7, id=3, wb_rdy_i=1 -> wb_vld_o with id=3, result 14, one cycle after div_vld_i. REMU 100/7 -> 2.
- DIV 0xFFFFFFF9 / 2 and REM of the same operands -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Fast path: DIVU 5/0 -> div_vld_i in the handshake cycle. Expect inflight_q to stay 0, then result 0xFFFFFFFF.
- Backpressure: wb_rdy_i=0 with RES_DEPTH=2. After 2 results, div_vld_o stays 0 and issue_rdy_o=0 with 1 request held. Raising wb_rdy_i drains in order: ids 1, 2, then 3.
- Flush during a 32-cycle division -> all valids drop next cycle, a new request is accepted, and only its result appears.
- Inject div_vld_i with nothing inflight -> proto_err_o=1 and stays set until rst_i.
